// File: rtl/pong_game_ctrl.sv
// Pong game controller: one update per frame tick.
// Sequences serve, play, miss and game-over, and owns the ball, the bar,
// the lives and the score. All outputs come straight from flops.
module pong_game_ctrl #(
    parameter int BALL_V       = 2,
    parameter int BAR_V        = 4,
    parameter int BAR_H        = 72,
    parameter int BALL_SIZE    = 8,
    parameter int WALL_R       = 35,
    parameter int BAR_XL       = 600,
    parameter int SERVE_FRAMES = 60,
    parameter int LIVES_INIT   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] bar_top,
    output logic       ball_visible,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, MISS, OVER} state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    // Comparisons run one bit wider than the screen coordinates so that
    // edge + size + step sums never wrap.
    localparam logic [10:0] BALLV  = 11'(BALL_V);
    localparam logic [10:0] BARV   = 11'(BAR_V);
    localparam logic [10:0] BARH   = 11'(BAR_H);
    localparam logic [10:0] BSIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] WALLR  = 11'(WALL_R);
    localparam logic [10:0] BARXL  = 11'(BAR_XL);
    localparam logic [10:0] XLIM   = 11'(640 - BALL_SIZE);
    localparam logic [10:0] YMAX   = 11'd479;

    localparam logic [9:0] BALL_STEP = 10'(BALL_V);
    localparam logic [9:0] BAR_STEP  = 10'(BAR_V);
    localparam logic [9:0] BAR_LOW   = 10'(480 - BAR_H);
    localparam logic [9:0] X_INIT    = 10'd580;
    localparam logic [9:0] Y_INIT    = 10'd238;
    localparam logic [9:0] BAR_INIT  = 10'd204;
    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t           state;
    logic             dirRight;
    logic             dirDown;
    logic [CNT_W-1:0] serveCnt;

    logic [10:0] bx, by, bt;
    logic [9:0]  xNext, yNext, barNext;
    logic        dirRightNext, dirDownNext;
    logic        hit, miss;
    logic        enterServe;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign bt = {1'b0, bar_top};

    // Serve positions are loaded whenever a new rally begins: from IDLE or
    // OVER on start, or after a miss that still leaves a life.
    assign enterServe = (start && (state == IDLE || state == OVER)) ||
                        (state == MISS && lives != 2'd1);

    // Next ball position and direction for a play tick; x and y are
    // evaluated independently from the current registers.
    always_comb begin
        xNext        = ball_x;
        yNext        = ball_y;
        dirRightNext = dirRight;
        dirDownNext  = dirDown;
        hit          = 1'b0;
        miss         = 1'b0;
        if (!dirRight) begin
            if (bx < WALLR + 11'd1 + BALLV) begin
                dirRightNext = 1'b1;
                xNext        = ball_x + BALL_STEP;
            end else begin
                xNext = ball_x - BALL_STEP;
            end
        end else if ((bx + BSIZE - 11'd1 < BARXL) &&
                     (bx + BSIZE - 11'd1 + BALLV >= BARXL) &&
                     (by + BSIZE - 11'd1 >= bt) &&
                     (by <= bt + BARH - 11'd1)) begin
            hit          = 1'b1;
            dirRightNext = 1'b0;
            xNext        = ball_x - BALL_STEP;
        end else if (bx + BALLV > XLIM) begin
            miss = 1'b1;
        end else begin
            xNext = ball_x + BALL_STEP;
        end
        if (!dirDown) begin
            if (by < BALLV) begin
                dirDownNext = 1'b1;
                yNext       = ball_y + BALL_STEP;
            end else begin
                yNext = ball_y - BALL_STEP;
            end
        end else if (by + BSIZE - 11'd1 + BALLV > YMAX) begin
            dirDownNext = 1'b0;
            yNext       = ball_y - BALL_STEP;
        end else begin
            yNext = ball_y + BALL_STEP;
        end
    end

    // Next bar position, clamped to the screen; both buttons cancel out.
    always_comb begin
        barNext = bar_top;
        if (btn_up && !btn_down) begin
            barNext = (bt >= BARV) ? bar_top - BAR_STEP : 10'd0;
        end else if (btn_down && !btn_up) begin
            barNext = (bt + BARH - 11'd1 + BARV <= YMAX) ? bar_top + BAR_STEP : BAR_LOW;
        end
    end

    // Game state machine and all registered game objects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ball_x       <= X_INIT;
            ball_y       <= Y_INIT;
            dirRight     <= 1'b0;
            dirDown      <= 1'b1;
            bar_top      <= BAR_INIT;
            ball_visible <= 1'b0;
            lives        <= LIVES_RST;
            score        <= 8'd0;
            game_over    <= 1'b0;
            serveCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= SERVE;
                end
                SERVE: begin
                    if (refr_tick) begin
                        bar_top  <= barNext;
                        serveCnt <= serveCnt + 1'b1;
                        if (serveCnt == SERVE_LAST) state <= PLAY;
                    end
                end
                PLAY: begin
                    if (refr_tick) begin
                        bar_top <= barNext;
                        if (miss) begin
                            state        <= MISS;
                            ball_visible <= 1'b0;
                        end else begin
                            ball_x   <= xNext;
                            ball_y   <= yNext;
                            dirRight <= dirRightNext;
                            dirDown  <= dirDownNext;
                            if (hit && score != 8'hFF) score <= score + 8'd1;
                        end
                    end
                end
                MISS: begin
                    if (lives == 2'd1) begin
                        lives     <= 2'd0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        lives <= lives - 2'd1;
                        state <= SERVE;
                    end
                end
                OVER: begin
                    if (start) begin
                        lives     <= LIVES_RST;
                        score     <= 8'd0;
                        game_over <= 1'b0;
                        state     <= SERVE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enterServe) begin
                ball_x       <= X_INIT;
                ball_y       <= Y_INIT;
                dirRight     <= 1'b0;
                dirDown      <= 1'b1;
                ball_visible <= 1'b1;
                serveCnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve, bar, walls, hit, miss,
// game over, restart, asynchronous reset and score saturation.
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic reset, refr_tick, start, btn_up, btn_down;
    logic [9:0] ball_x, ball_y, bar_top;
    logic ball_visible, game_over;
    logic [1:0] lives;
    logic [7:0] score;

    // Second instance with a near bar and a full-height paddle so the ball
    // bounces quickly and the score can be driven to saturation.
    logic tick2, start2, up2, down2;
    logic [9:0] satBallX, satBallY, satBarTop;
    logic satVisible, satOver;
    logic [1:0] satLives;
    logic [7:0] satScore;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .refr_tick(refr_tick), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .ball_x(ball_x), .ball_y(ball_y),
        .bar_top(bar_top), .ball_visible(ball_visible), .lives(lives),
        .score(score), .game_over(game_over)
    );

    pong_game_ctrl #(.BAR_XL(60), .BAR_H(480)) sat (
        .clk(clk), .reset(reset), .refr_tick(tick2), .start(start2),
        .btn_up(up2), .btn_down(down2), .ball_x(satBallX), .ball_y(satBallY),
        .bar_top(satBarTop), .ball_visible(satVisible), .lives(satLives),
        .score(satScore), .game_over(satOver)
    );

    task automatic tick(input logic up, input logic down);
        @(negedge clk);
        btn_up = up; btn_down = down; refr_tick = 1'b1;
        @(negedge clk);
        refr_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic ticks(input int n, input logic up, input logic down);
        repeat (n) tick(up, down);
    endtask

    task automatic pulseStart(input logic withTick);
        @(negedge clk);
        start = 1'b1; refr_tick = withTick;
        @(negedge clk);
        start = 1'b0; refr_tick = 1'b0;
    endtask

    task automatic ticks2(input int n, input logic down);
        repeat (n) begin
            @(negedge clk);
            tick2 = 1'b1; down2 = down;
            @(negedge clk);
            tick2 = 1'b0; down2 = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ball_x, ball_y, bar_top} !== {10'd580, 10'd238, 10'd204}) begin
            miscompares++;
            $display("[TB] FAIL reset_pos: got x=%0d y=%0d bar=%0d expected 580 238 204", ball_x, ball_y, bar_top);
        end
        vectors++;
        if ({lives, score, ball_visible, game_over} !== {2'd3, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got lives=%0d score=%0d vis=%0b over=%0b expected 3 0 0 0", lives, score, ball_visible, game_over);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        ticks(5, 1'b0, 1'b1);
        vectors++;
        if ({bar_top, ball_x, ball_visible} !== {10'd204, 10'd580, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL idle_ignores_tick: got bar=%0d x=%0d vis=%0b expected 204 580 0", bar_top, ball_x, ball_visible);
        end
    endtask

    task automatic test_serve();
        pulseStart(1'b1);
        vectors++;
        if ({ball_visible, ball_x, ball_y} !== {1'b1, 10'd580, 10'd238}) begin
            miscompares++;
            $display("[TB] FAIL serve_entry: got vis=%0b x=%0d y=%0d expected 1 580 238", ball_visible, ball_x, ball_y);
        end
        ticks(60, 1'b0, 1'b0);
        vectors++;
        if ({ball_visible, ball_x, ball_y} !== {1'b1, 10'd580, 10'd238}) begin
            miscompares++;
            $display("[TB] FAIL serve_hold_60: got vis=%0b x=%0d y=%0d expected 1 580 238", ball_visible, ball_x, ball_y);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_visible, ball_x, ball_y} !== {1'b1, 10'd578, 10'd240}) begin
            miscompares++;
            $display("[TB] FAIL first_play_tick: got vis=%0b x=%0d y=%0d expected 1 578 240", ball_visible, ball_x, ball_y);
        end
    endtask

    task automatic test_bar();
        tick(1'b1, 1'b0);
        vectors++;
        if ({bar_top, ball_x} !== {10'd200, 10'd576}) begin
            miscompares++;
            $display("[TB] FAIL bar_up_one: got bar=%0d x=%0d expected 200 576", bar_top, ball_x);
        end
        pulseStart(1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_visible, ball_x} !== {1'b1, 10'd574}) begin
            miscompares++;
            $display("[TB] FAIL start_ignored_in_play: got vis=%0b x=%0d expected 1 574", ball_visible, ball_x);
        end
        ticks(59, 1'b1, 1'b0);
        vectors++;
        if (bar_top !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL bar_clamp_top: got %0d expected 0", bar_top);
        end
        ticks(110, 1'b0, 1'b1);
        vectors++;
        if (bar_top !== 10'd408) begin
            miscompares++;
            $display("[TB] FAIL bar_clamp_bottom: got %0d expected 408", bar_top);
        end
        ticks(5, 1'b1, 1'b1);
        vectors++;
        if ({bar_top, ball_x, ball_y} !== {10'd408, 10'd226, 10'd352}) begin
            miscompares++;
            $display("[TB] FAIL bar_both_hold: got bar=%0d x=%0d y=%0d expected 408 226 352", bar_top, ball_x, ball_y);
        end
    endtask

    task automatic test_reset_midplay();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({ball_x, ball_y, bar_top, lives, score, ball_visible} !==
            {10'd580, 10'd238, 10'd204, 2'd3, 8'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got x=%0d y=%0d bar=%0d lives=%0d score=%0d vis=%0b expected 580 238 204 3 0 0",
                     ball_x, ball_y, bar_top, lives, score, ball_visible);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_visible, ball_x} !== {1'b0, 10'd580}) begin
            miscompares++;
            $display("[TB] FAIL reset_to_idle: got vis=%0b x=%0d expected 0 580", ball_visible, ball_x);
        end
    endtask

    task automatic test_walls();
        pulseStart(1'b0);
        ticks(30, 1'b0, 1'b1);
        vectors++;
        if (bar_top !== 10'd324) begin
            miscompares++;
            $display("[TB] FAIL serve_bar_down: got %0d expected 324", bar_top);
        end
        ticks(30 + 117, 1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd346, 10'd472}) begin
            miscompares++;
            $display("[TB] FAIL before_floor: got x=%0d y=%0d expected 346 472", ball_x, ball_y);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd344, 10'd470}) begin
            miscompares++;
            $display("[TB] FAIL floor_bounce: got x=%0d y=%0d expected 344 470", ball_x, ball_y);
        end
        ticks(154, 1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd36, 10'd162}) begin
            miscompares++;
            $display("[TB] FAIL before_wall: got x=%0d y=%0d expected 36 162", ball_x, ball_y);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd38, 10'd160}) begin
            miscompares++;
            $display("[TB] FAIL wall_bounce: got x=%0d y=%0d expected 38 160", ball_x, ball_y);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd40, 10'd158}) begin
            miscompares++;
            $display("[TB] FAIL after_wall: got x=%0d y=%0d expected 40 158", ball_x, ball_y);
        end
    endtask

    task automatic test_hit();
        ticks(276, 1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y, score} !== {10'd592, 10'd394, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL before_hit: got x=%0d y=%0d score=%0d expected 592 394 0", ball_x, ball_y, score);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y, score} !== {10'd590, 10'd396, 8'd1}) begin
            miscompares++;
            $display("[TB] FAIL bar_hit: got x=%0d y=%0d score=%0d expected 590 396 1", ball_x, ball_y, score);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd588, 10'd398}) begin
            miscompares++;
            $display("[TB] FAIL after_hit: got x=%0d y=%0d expected 588 398", ball_x, ball_y);
        end
    endtask

    task automatic test_miss();
        ticks(90, 1'b1, 1'b0);
        vectors++;
        if (bar_top !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL bar_moved_away: got %0d expected 0", bar_top);
        end
        ticks(484, 1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y, ball_visible} !== {10'd632, 10'd342, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL before_miss: got x=%0d y=%0d vis=%0b expected 632 342 1", ball_x, ball_y, ball_visible);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y, ball_visible, lives} !== {10'd632, 10'd342, 1'b0, 2'd3}) begin
            miscompares++;
            $display("[TB] FAIL miss_state: got x=%0d y=%0d vis=%0b lives=%0d expected 632 342 0 3", ball_x, ball_y, ball_visible, lives);
        end
        @(negedge clk);
        vectors++;
        if ({ball_x, ball_y, ball_visible, lives, score} !== {10'd580, 10'd238, 1'b1, 2'd2, 8'd1}) begin
            miscompares++;
            $display("[TB] FAIL reserve_after_miss: got x=%0d y=%0d vis=%0b lives=%0d score=%0d expected 580 238 1 2 1",
                     ball_x, ball_y, ball_visible, lives, score);
        end
        ticks(630, 1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd632, 10'd434}) begin
            miscompares++;
            $display("[TB] FAIL second_rally: got x=%0d y=%0d expected 632 434", ball_x, ball_y);
        end
        tick(1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (lives !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL second_miss_lives: got %0d expected 1", lives);
        end
        ticks(631, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if ({lives, game_over, ball_visible, score} !== {2'd0, 1'b1, 1'b0, 8'd1}) begin
            miscompares++;
            $display("[TB] FAIL game_over: got lives=%0d over=%0b vis=%0b score=%0d expected 0 1 0 1", lives, game_over, ball_visible, score);
        end
    endtask

    task automatic test_over_restart();
        tick(1'b0, 1'b1);
        vectors++;
        if ({bar_top, game_over} !== {10'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL over_bar_frozen: got bar=%0d over=%0b expected 0 1", bar_top, game_over);
        end
        pulseStart(1'b1);
        vectors++;
        if ({lives, score, game_over, ball_visible, ball_x} !== {2'd3, 8'd0, 1'b0, 1'b1, 10'd580}) begin
            miscompares++;
            $display("[TB] FAIL restart: got lives=%0d score=%0d over=%0b vis=%0b x=%0d expected 3 0 0 1 580",
                     lives, score, game_over, ball_visible, ball_x);
        end
        ticks(60, 1'b0, 1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if ({ball_x, ball_y} !== {10'd578, 10'd240}) begin
            miscompares++;
            $display("[TB] FAIL restart_serve_len: got x=%0d y=%0d expected 578 240", ball_x, ball_y);
        end
    endtask

    task automatic test_score_saturation();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ticks2(1, 1'b1);
        vectors++;
        if (satBarTop !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL sat_bar_low: got %0d expected 0", satBarTop);
        end
        ticks2(59 + 281, 1'b0);
        vectors++;
        if ({satScore, satBallX} !== {8'd1, 10'd50}) begin
            miscompares++;
            $display("[TB] FAIL sat_first_hit: got score=%0d x=%0d expected 1 50", satScore, satBallX);
        end
        ticks2(4064, 1'b0);
        vectors++;
        if ({satScore, satBallX} !== {8'd255, 10'd50}) begin
            miscompares++;
            $display("[TB] FAIL sat_reach_255: got score=%0d x=%0d expected 255 50", satScore, satBallX);
        end
        ticks2(16, 1'b0);
        vectors++;
        if ({satScore, satBallX} !== {8'd255, 10'd50}) begin
            miscompares++;
            $display("[TB] FAIL sat_hold_255: got score=%0d x=%0d expected 255 50", satScore, satBallX);
        end
    endtask

    initial begin
        reset = 1'b1; refr_tick = 1'b0; start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick2 = 1'b0; start2 = 1'b0; up2 = 1'b0; down2 = 1'b0;
        $display("[TB] pong_game_ctrl directed test start");
        test_reset();
        test_idle();
        test_serve();
        test_bar();
        test_reset_midplay();
        test_walls();
        test_hit();
        test_miss();
        test_over_restart();
        test_score_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
